seq_mag_comparator: RTL

//  Parametrised, clocked magnitude comparator; next generation of the 8-bit combinational eq/gt comparator.

---
 rtl/seq_mag_comparator.sv | 127 ++++++++++++
 1 files changed

// File: rtl/seq_mag_comparator.sv
// Sequential MSB-first magnitude comparator, DIGIT bits per cycle, unsigned or two's complement.
// Define EARLY_EXIT_EN to finish on the first differing digit instead of always scanning ND digits.
module seq_mag_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             eq_o,
  output logic             gt_o,
  output logic             lt_o
);

  localparam int ND = WIDTH / DIGIT;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [CW-1:0] LastDigit = CW'(ND - 1);
  localparam logic [WIDTH-1:0] MsbMask = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] aReg_q, bReg_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, eq_q, gt_q, lt_q;

  logic [WIDTH-1:0] aCap_d, bCap_d;
  logic [DIGIT-1:0] aDigit, bDigit;
  logic             digitDiff, digitGt, lastDigit;

  // Offset binary: flipping the sign bits makes an unsigned compare order signed values correctly.
  assign aCap_d = signed_mode_i ? (a_i ^ MsbMask) : a_i;
  assign bCap_d = signed_mode_i ? (b_i ^ MsbMask) : b_i;

  // Operands shift left each cycle, so the digit under test is always the top slice.
  assign aDigit    = aReg_q[WIDTH-1 -: DIGIT];
  assign bDigit    = bReg_q[WIDTH-1 -: DIGIT];
  assign digitDiff = (aDigit != bDigit);
  assign digitGt   = (aDigit > bDigit);
  assign lastDigit = (cnt_q == LastDigit);

`ifndef EARLY_EXIT_EN
  logic decided;
  assign decided = gt_q | lt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      aReg_q  <= '0;
      bReg_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= COMPARE;
            aReg_q  <= aCap_d;
            bReg_q  <= bCap_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
          end
        end
        COMPARE: begin
          aReg_q <= aReg_q << DIGIT;
          bReg_q <= bReg_q << DIGIT;
`ifdef EARLY_EXIT_EN
          if (digitDiff || lastDigit) begin
            gt_q    <= digitDiff && digitGt;
            lt_q    <= digitDiff && !digitGt;
            eq_q    <= !digitDiff;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`else
          // Only the first differing digit decides; later digits are ignored.
          if (!decided && digitDiff) begin
            gt_q <= digitGt;
            lt_q <= !digitGt;
          end
          if (lastDigit) begin
            eq_q    <= !decided && !digitDiff;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign eq_o   = eq_q;
  assign gt_o   = gt_q;
  assign lt_o   = lt_q;

endmodule
